seq_shift_add_mult: RTL and testbench

//  Iterative unsigned shift-add multiplier; the product stage fed by the multiplier bench driver.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/seq_shift_add_mult.sv | 110 +++++++++++
 tb/tb_seq_shift_add_mult.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier and its bench driver.
//   DefaultWidth          : default operand width (product is twice this)
//   S_IDLE/S_RUN/S_DONE   : FSM state encodings
//   state_e               : typed state enum built on those encodings
//   cnt_width()           : iteration counter width for a given operand width
package mult_pkg;

  localparam int unsigned DefaultWidth = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } state_e;

  // A 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk1   in   1        clock, all state on posedge
//   rst_n  in   1        synchronous active-low reset
//   start  in   1        request, accepted only when idle
//   A      in   WIDTH    multiplicand, captured on accepted start
//   B      in   WIDTH    multiplier, captured on accepted start
//   F      out  2*WIDTH  product, valid from done until next accepted start
//   busy   out  1        registered, high while running or finishing
//   done   out  1        registered one-cycle pulse, F valid
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] F,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   f_q, f_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // State register plus all registered datapath and outputs.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next values; outputs are registered so nothing
  // combinational reaches the ports.
  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = {{WIDTH{1'b0}}, A};
          mplr_d  = B;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
      end
      StDone: begin
        f_d    = acc_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
    // busy tracks the state being entered, so it lines up with RUN/DONE.
    busy_d = (state_d == StRun) || (state_d == StDone);
  end

  assign F    = f_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: table vectors, directed
// multi-cycle sequences, an operand sweep and random operands against a
// plain-arithmetic reference.
module tb_seq_shift_add_mult;
  import mult_pkg::*;

  localparam int unsigned W   = DefaultWidth;
  localparam int          Lat = W + 1;      // edges from accepted start to done
  localparam int          Gap = W + 2;      // cycles between back-to-back products

  logic             clk1 = 1'b0;
  logic             rst_n;
  logic             start;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic [2*W-1:0]   F;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int a;
    int b;
    int f;
  } vec_t;

  vec_t vecs[7];

  always #5 clk1 = ~clk1;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .F     (F),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  function automatic int ref_mult(input int a, input int b);
    return a * b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Issue one start pulse and wait (bounded) for done.
  task automatic run_op(input int a, input int b, output int f, output int lat,
                        output logic saw_busy);
    A = W'(a);
    B = W'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    saw_busy = busy;
    lat = -1;
    f = 0;
    for (int k = 1; k <= 3 * Lat; k++) begin
      tick();
      if (done) begin
        lat = k;
        f = int'(F);
        break;
      end
    end
  endtask

  task automatic do_op(input string name, input int a, input int b);
    int f;
    int lat;
    logic sb;
    run_op(a, b, f, lat, sb);
    check({name, " F"}, f, ref_mult(a, b));
    check({name, " latency"}, lat, Lat);
    check({name, " busy"}, {31'b0, sb}, 1);
    tick();
    check({name, " done single"}, {31'b0, done}, 0);
    check({name, " F hold"}, {16'b0, F}, ref_mult(a, b));
  endtask

  initial begin
    int pulses;
    int f;
    int lat;
    int prev;
    int fails_before;

    vecs[0] = '{a: 1,   b: 1,   f: 1};
    vecs[1] = '{a: 2,   b: 1,   f: 2};
    vecs[2] = '{a: 255, b: 255, f: 65025};
    vecs[3] = '{a: 0,   b: 200, f: 0};
    vecs[4] = '{a: 200, b: 0,   f: 0};
    vecs[5] = '{a: 128, b: 2,   f: 256};
    vecs[6] = '{a: 6,   b: 7,   f: 42};

    // Reset held two cycles with start high.
    rst_n = 1'b0;
    start = 1'b1;
    A = 8'd5;
    B = 8'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset F", {16'b0, F}, 0);
      check("reset busy", {31'b0, busy}, 0);
      check("reset done", {31'b0, done}, 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle busy", {31'b0, busy}, 0);

    // Table-driven vectors; last one leaves F=42 for the busy-ignore case.
    foreach (vecs[i]) begin
      int lt;
      logic sb;
      run_op(vecs[i].a, vecs[i].b, f, lt, sb);
      check($sformatf("vec%0d F", i), f, vecs[i].f);
      check($sformatf("vec%0d latency", i), lt, Lat);
      tick();
      check($sformatf("vec%0d done single", i), {31'b0, done}, 0);
    end

    // start while busy is ignored; previous product stays visible during RUN.
    A = 8'd3;
    B = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    lat = -1;
    f = 0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 2) begin
        check("ignore F held in run", {16'b0, F}, 42);
        start = 1'b1;
        A = 8'd7;
        B = 8'd7;
      end else if (k == 3) begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        f = int'(F);
        lat = k;
      end
    end
    check("ignore pulses", pulses, 1);
    check("ignore F", f, 15);
    check("ignore latency", lat, Lat);

    // start held high: one product every Gap cycles.
    A = 8'd12;
    B = 8'd13;
    start = 1'b1;
    tick();
    pulses = 0;
    prev = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        pulses++;
        check("b2b F", {16'b0, F}, 156);
        if (prev >= 0) check("b2b spacing", k - prev, Gap);
        else check("b2b first latency", k, Lat);
        prev = k;
      end
    end
    start = 1'b0;
    check("b2b pulses", pulses, 4);
    for (int k = 0; k < 12; k++) tick();

    // Reset in the middle of an operation discards it.
    A = 8'd9;
    B = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    rst_n = 1'b0;
    tick();
    check("midrst F", {16'b0, F}, 0);
    check("midrst busy", {31'b0, busy}, 0);
    check("midrst done", {31'b0, done}, 0);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) pulses++;
    end
    check("midrst no done", pulses, 0);
    check("midrst F after", {16'b0, F}, 0);
    do_op("after midrst", 9, 9);

    // Operand sweep.
    fails_before = n_fail;
    for (int a = 2; a <= 19; a++) begin
      for (int b = 2; b <= 19; b++) begin
        logic sb;
        run_op(a, b, f, lat, sb);
        check($sformatf("sweep %0dx%0d F", a, b), f, ref_mult(a, b));
        check($sformatf("sweep %0dx%0d latency", a, b), lat, Lat);
      end
    end
    $display("sweep: %0d failing comparisons", n_fail - fails_before);

    // Random operands.
    for (int i = 0; i < 30; i++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      do_op($sformatf("rand %0dx%0d", ra, rb), ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
